apb_ram_slave: RTL
==================

APB_RAM_SLAVE -- requirements
Module: apb_ram_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits; legal values are 8, 16 and 32.
REQ-002 SHALL have parameter ADDR_W, default 8, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 16, number of DATA_W words; legal values are 2 to 64, and DEPTH*(DATA_W/8) must be no more than 2^ADDR_W.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, wait states inserted per transfer; legal values are 0 to 15.
REQ-005 SHALL have port pclk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port preset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port psel, input, 1 bit: slave select.
REQ-008 SHALL have port penable, input, 1 bit: access-phase indicator.
REQ-009 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port paddr, input, ADDR_W bits: byte address.
REQ-011 SHALL have port pwdata, input, DATA_W bits: write data.
REQ-012 SHALL have port pstrb, input, DATA_W/8 bits: write byte-lane enables.
REQ-013 SHALL have port prdata, output, DATA_W bits: read data.
REQ-014 SHALL have port pready, output, 1 bit: transfer complete.
REQ-015 SHALL have port pslverr, output, 1 bit: transfer error, valid only while pready=1.

Function
REQ-016 SHALL implement the states IDLE and ACCESS, plus a 4-bit wait counter.
REQ-017 IDLE: psel=1 and penable=0 (setup phase) SHALL capture paddr/pwrite, load the counter with WAIT_CYCLES, and move to ACCESS on the same edge.
REQ-018 IDLE: penable=1 without a preceding setup SHALL be ignored; the state stays IDLE and pready stays 0.
REQ-019 ACCESS: pready SHALL be 1 exactly when psel=1, penable=1 and counter=0, so the transfer has WAIT_CYCLES wait states.
REQ-020 ACCESS: while the counter is non-zero and psel=penable=1, the counter SHALL decrement each cycle.
REQ-021 The completion cycle (pready=1) SHALL return the state to IDLE; a setup phase on the very next cycle SHALL be accepted (back-to-back transfers).
REQ-022 ACCESS: psel=0 SHALL abort the transfer to IDLE with no memory write and no prdata update.
REQ-023 Word index SHALL be paddr >> log2(DATA_W/8).
REQ-024 An error SHALL be flagged when any paddr bits below log2(DATA_W/8) are non-zero (misaligned) or when word index >= DEPTH.
REQ-025 pslverr SHALL equal the captured error flag when pready=1, and SHALL be 0 otherwise.
REQ-026 Writes SHALL commit on the completion-cycle edge, updating only the byte lanes whose pstrb bit is 1; an errored write SHALL not modify memory.
REQ-027 Reads SHALL load prdata from memory on the setup edge; on error prdata SHALL be loaded with 0.
REQ-028 prdata SHALL hold its value until the next read is loaded; writes SHALL not change prdata.
REQ-029 pstrb SHALL be ignored on reads.
REQ-030 Parameter values outside their legal ranges SHALL stop elaboration with an error.

Reset
REQ-031 Asserting preset SHALL immediately force state=IDLE, counter=0, prdata=0, pready=0, pslverr=0 and every memory word to 0.
REQ-032 Reset during ACCESS SHALL discard the transfer, including the pending write.
REQ-033 After reset deassertion, the first edge with a setup phase SHALL start a transfer normally.

Structure
REQ-034 Package apb_pkg SHALL hold the state enum (IDLE, ACCESS) and the 4-bit counter width constant.
REQ-035 Memory storage and byte-lane write logic SHALL be the sub-module apb_ram_core, parameterised by DATA_W and DEPTH, with one write port and one read port.
REQ-036 FSM, counter, address decode and error logic SHALL reside in apb_ram_slave.

Verification
REQ-037 DATA_W=32, WAIT_CYCLES=0: write 0xDEADBEEF to 0x04 with pstrb=0xF, then read 0x04 -> prdata=0xDEADBEEF, pready=1 in the first access cycle, pslverr=0.
REQ-038 Write 0x11223344 to 0x08 with pstrb=0xF, then write 0xAABBCCDD to 0x08 with pstrb=0x5, then read 0x08 -> prdata=0x11BB33DD.
REQ-039 WAIT_CYCLES=3: a read -> pready low for 3 access cycles, high in the 4th, counter reloaded for the next transfer.
REQ-040 DEPTH=16: write to 0x40 and write to 0x02 -> pslverr=1 with pready=1 for each, memory unchanged; a read of 0x40 returns 0.
REQ-041 Drop psel mid-wait (WAIT_CYCLES=2) during a write of 0x55 to 0x0C -> no pready, later read of 0x0C returns the old value; preset asserted mid-access -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB RAM slave.
//   apb_state_e : transfer FSM states (IDLE, ACCESS)
//   CNT_W       : width of the wait-state counter
//   wait_cnt_t  : wait-state counter type
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] wait_cnt_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_ram_core.sv
// -----------------------------------------------------------------------------
// apb_ram_core
// Word-organised RAM with one byte-lane-masked write port and one
// asynchronous read port. Every word clears to zero on reset.
// Ports:
//   pclk   in  clock, rising edge
//   preset in  asynchronous active-high reset
//   we     in  write enable (commits on the rising edge)
//   waddr  in  write word index
//   wdata  in  write data
//   wstrb  in  write byte-lane enables, one bit per byte of wdata
//   raddr  in  read word index
//   rdata  out read data (combinational from raddr)
// -----------------------------------------------------------------------------
module apb_ram_core
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Byte-lane merge: only lanes with a set strobe take the new data.
  // Indices beyond DEPTH (non power-of-two depths) are never written.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mem_d = mem_q;
    if (we && (32'(waddr) < DEPTH)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      // NOTE: the storage is cleared on reset because the block must read back
      // zero from every word after reset; this keeps it in flops rather than a
      // RAM macro, which is acceptable at these depths.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every flop samples the pre-edge values of its inputs.
      mem_q <= mem_d;
    end
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule : apb_ram_core

// File: rtl/apb_ram_slave.sv
// -----------------------------------------------------------------------------
// apb_ram_slave
// APB slave fronting a small word RAM, with a fixed number of wait states per
// transfer and error reporting for misaligned or out-of-range addresses.
// Ports:
//   pclk    in  clock, rising edge
//   preset  in  asynchronous active-high reset
//   psel    in  slave select
//   penable in  access-phase indicator
//   pwrite  in  1 = write, 0 = read
//   paddr   in  byte address
//   pwdata  in  write data
//   pstrb   in  write byte-lane enables (ignored on reads)
//   prdata  out read data, loaded on the setup edge of a read and held
//   pready  out transfer complete
//   pslverr out transfer error, only meaningful while pready = 1
// -----------------------------------------------------------------------------
module apb_ram_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  // Byte-offset bits inside one word; any of them set means misaligned.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(STRB_W - 1);
  localparam wait_cnt_t         WAIT_INIT = CNT_W'(WAIT_CYCLES);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
    $error("apb_ram_slave: DATA_W must be 8, 16 or 32");
  end
  if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
    $error("apb_ram_slave: DEPTH must be in 2..64");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_ram_slave: WAIT_CYCLES must be in 0..15");
  end
  if (ADDR_W < 1) begin : g_bad_addr_w
    $error("apb_ram_slave: ADDR_W must be at least 1");
  end
  if (ADDR_W < 31 && (DEPTH * (DATA_W / 8)) > (1 << ADDR_W)) begin : g_bad_span
    $error("apb_ram_slave: DEPTH*(DATA_W/8) exceeds the byte address space");
  end

  // ---------------------------------------------------------------------------
  // Address decode of the live bus address (used on the setup edge)
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              setup_err;
  logic [IDX_W-1:0]  setup_idx;

  assign word_idx     = paddr >> OFF_W;
  assign misaligned   = |(paddr & OFF_MASK);
  // One extra bit so DEPTH is representable even when it equals 2^ADDR_W.
  assign out_of_range = {1'b0, word_idx} >= (ADDR_W + 1)'(DEPTH);
  assign setup_err    = misaligned | out_of_range;
  assign setup_idx    = IDX_W'(word_idx);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  apb_state_e        state_q,  state_d;
  wait_cnt_t         cnt_q,    cnt_d;
  logic              write_q,  write_d;
  logic              err_q,    err_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic              ready_d;
  logic              slverr_d;
  logic              mem_we;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    err_d    = err_q;
    idx_d    = idx_q;
    prdata_d = prdata_q;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Only a genuine setup phase starts a transfer; a bare penable is ignored.
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = WAIT_INIT;
          write_d = pwrite;
          err_d   = setup_err;
          idx_d   = setup_idx;
          // Read data is fetched on the setup edge so it is stable for the
          // whole access phase; an errored read returns zero.
          if (!pwrite) begin
            prdata_d = setup_err ? '0 : ram_rdata;
          end
        end
      end

      ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: nothing is committed.
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q == '0) begin
            ready_d  = 1'b1;
            slverr_d = err_q;
            state_d  = IDLE;
            mem_we   = write_q && !err_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      prdata_q <= prdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Write data and strobes are taken live on the completion edge,
  // where the bus holds them stable; the read port follows the live address.
  // ---------------------------------------------------------------------------
  apb_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram_core (
    .pclk   (pclk),
    .preset (preset),
    .we     (mem_we),
    .waddr  (idx_q),
    .wdata  (pwdata),
    .wstrb  (pstrb),
    .raddr  (setup_idx),
    .rdata  (ram_rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = ready_d;
  assign pslverr = slverr_d;

endmodule : apb_ram_slave
